// File: rtl/divisor_pkg.sv
// Shared widths, state encoding and constants for the sequential restoring divider.
package divisor_pkg;

  localparam int N_DD  = 8;
  localparam int N_DR  = 4;
  localparam int CNT_W = $clog2(N_DD + 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Quotient reported when the divisor is zero.
  localparam logic [N_DD-1:0] QUOT_DIV0 = '1;

endpackage

// File: rtl/divisor_if.sv
// Operand/result bundle between the ALU (master) and the divider (slave).
interface divisor_if;
  import divisor_pkg::*;

  // Handshake: init is a level request sampled only in IDLE; done rises when
  // Q/R/div0 are valid and stays high until init is seen low, so every
  // operation needs at least one low-init edge in DONE before the next accept.
  logic            init;
  logic [N_DD-1:0] DV;
  logic [N_DR-1:0] DR;
  logic [N_DD-1:0] Q;
  logic [N_DR-1:0] R;
  logic            done;
  logic            div0;

  modport master (output init, DV, DR, input  Q, R, done, div0);
  modport slave  (input  init, DV, DR, output Q, R, done, div0);

endinterface

// File: rtl/divisor_paso_division.sv
// One restoring compare-subtract step: produces the next partial remainder and quotient bit.
module paso_division
  import divisor_pkg::*;
(
  input  logic [N_DR:0]   t,
  input  logic [N_DR-1:0] d,
  output logic [N_DR-1:0] p_next,
  output logic            q_bit
);

  // When T >= D the difference is below D, so it always fits N_DR bits;
  // when T < D the top bit of T is necessarily zero.
  always_comb begin
    q_bit  = (t >= {1'b0, d});
    p_next = q_bit ? (t[N_DR-1:0] - d) : t[N_DR-1:0];
  end

endmodule

// File: rtl/divisor.sv
// Sequential restoring divider: one quotient bit per clock, init/done handshake.
module divisor
  import divisor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  divisor_if.slave   bus,
  output logic [1:0] state_dbg
);

  logic [1:0]      state;
  logic [N_DD-1:0] a;
  logic [N_DR-1:0] d;
  logic [N_DR-1:0] p;
  logic [N_DD-2:0] w;
  logic [CNT_W-1:0] cnt;
  logic [N_DD-1:0] q_reg;
  logic [N_DR-1:0] r_reg;
  logic            div0_reg;

  logic [N_DR:0]   t;
  logic [N_DR-1:0] p_next;
  logic            q_bit;

  assign t = {p, a[N_DD-1]};

  paso_division u_paso (
    .t      (t),
    .d      (d),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  // The partial remainder never exceeds D-1, so its extra MSB is not stored;
  // likewise the last quotient bit goes straight into Q, so W is one bit short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      d        <= '0;
      p        <= '0;
      w        <= '0;
      cnt      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      div0_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.init) begin
            if (bus.DR == '0) begin
              q_reg    <= QUOT_DIV0;
              r_reg    <= '0;
              div0_reg <= 1'b1;
              state    <= DONE;
            end else begin
              a        <= bus.DV;
              d        <= bus.DR;
              p        <= '0;
              w        <= '0;
              cnt      <= CNT_W'(N_DD);
              div0_reg <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          a   <= a << 1;
          p   <= p_next;
          w   <= {w[N_DD-3:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            q_reg <= {w, q_bit};
            r_reg <= p_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.init) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q     = q_reg;
  assign bus.R     = r_reg;
  assign bus.div0  = div0_reg;
  assign bus.done  = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_divisor.sv
// Scoreboard bench for divisor: directed cases, mid-run reset and random operands vs / and %.
module tb_divisor;
  import divisor_pkg::*;

  localparam int EXP_W = 1 + N_DD + N_DR;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  divisor_if bus();

  divisor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               lat_q[$];
  logic [N_DD-1:0]  held_q;
  logic [N_DR-1:0]  held_r;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned division; packed as {div0, Q, R}.
  function automatic logic [EXP_W-1:0] model(input int dv, input int dr);
    logic [N_DD-1:0] q;
    logic [N_DR-1:0] r;
    if (dr == 0) begin
      q = N_DD'((1 << N_DD) - 1);
      return {1'b1, q, {N_DR{1'b0}}};
    end
    q = N_DD'(dv / dr);
    r = N_DR'(dv % dr);
    return {1'b0, q, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.done, 1);
  endtask

  task automatic do_op(input int dv, input int dr, input bit hold);
    @(negedge clk);
    bus.DV   = N_DD'(dv);
    bus.DR   = N_DR'(dr);
    bus.init = 1'b1;
    exp_q.push_back(model(dv, dr));
    lat_q.push_back(cyc + 1 + ((dr == 0) ? 0 : N_DD));
    if (!hold) begin
      @(negedge clk);
      bus.init = 1'b0;
      bus.DV   = N_DD'($urandom);
      bus.DR   = N_DR'($urandom);
    end
    wait_done("op_done");
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        check("hold_done", bus.done, 1);
        check("hold_state", state_dbg, DONE);
      end
      bus.init = 1'b0;
      @(negedge clk);
      check("drop_idle", state_dbg, IDLE);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic             prev_done;
    logic [EXP_W-1:0] e;
    int               lat;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (bus.done && !prev_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e   = exp_q.pop_front();
            lat = lat_q.pop_front();
            check("result_q", bus.Q, e[N_DD+N_DR-1:N_DR]);
            check("result_r", bus.R, e[N_DR-1:0]);
            check("result_div0", bus.div0, e[EXP_W-1]);
            check("latency", cyc, lat);
            held_q = e[N_DD+N_DR-1:N_DR];
            held_r = e[N_DR-1:0];
          end
        end else if (!bus.done) begin
          check("hold_q", bus.Q, held_q);
          check("hold_r", bus.R, held_r);
        end
        prev_done = bus.done;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    bus.init = 1'b0;
    bus.DV   = '0;
    bus.DR   = '0;
    held_q   = '0;
    held_r   = '0;
    #1;
    check("reset_state", state_dbg, IDLE);
    check("reset_q", bus.Q, 0);
    check("reset_r", bus.R, 0);
    check("reset_done", bus.done, 0);
    check("reset_div0", bus.div0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(200, 7, 1'b0);
    do_op(255, 1, 1'b0);
    do_op(5, 9, 1'b0);
    do_op(144, 12, 1'b0);
    do_op(100, 0, 1'b0);
    do_op(9, 3, 1'b0);
    do_op(200, 7, 1'b1);

    // Abort 200/7 with an asynchronous reset in its 4th RUN cycle.
    @(negedge clk);
    bus.DV   = 8'd200;
    bus.DR   = 4'd7;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_state", state_dbg, RUN);
    rst_n  = 1'b0;
    held_q = '0;
    held_r = '0;
    #1;
    check("midreset_state", state_dbg, IDLE);
    check("midreset_q", bus.Q, 0);
    check("midreset_r", bus.R, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_div0", bus.div0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(144, 12, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(1, 15)),
            ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
